// File: rtl/shift_reg_32_pkg.sv
// shift_reg_32_pkg
// Mode-select encodings for the 32-bit universal shift register. The select
// value is {S1,S0}. Other blocks that drive the register (for example display
// scrolling) can import these names so they never hard-code raw bit patterns.
package shift_reg_32_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam int unsigned WIDTH = 32;

endpackage

// File: rtl/shift_reg_32_cell.sv
// shift_reg_32_cell
// One bit of the universal shift register: a 4:1 mux feeding a flip-flop
// with synchronous clear.
// Ports:
//   clk      rising-edge clock
//   clear    synchronous active-high clear, overrides the mode
//   mode     {S1,S0}: hold, take right neighbour, take left neighbour, load
//   rightIn  bit from the next-higher position (SR for bit 31)
//   leftIn   bit from the next-lower position (SL for bit 0)
//   loadIn   parallel-load data bit
//   q        stored bit
module shift_reg_32_cell
  import shift_reg_32_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] mode,
  input  logic       rightIn,
  input  logic       leftIn,
  input  logic       loadIn,
  output logic       q
);

  logic q_q;
  logic q_d;

  // Next-state selection. An undefined select falls to the default arm and
  // drives X, so a bad select never looks like a legal mode in simulation.
  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = rightIn;
      MODE_SHL:  q_d = leftIn;
      MODE_LOAD: q_d = loadIn;
      default:   q_d = 1'bx;
    endcase
  end

  // Storage flop; clear wins over every mode.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_32.sv
// shift_reg_32
// 32-bit universal shift register (a 74194 widened to 32 bits) with
// synchronous active-high clear. Built from 32 identical one-bit cells.
// Ports:
//   clk    rising-edge clock
//   clear  synchronous active-high clear, Q <= 0, overrides mode
//   S1,S0  mode select: 00 hold, 01 shift right, 10 shift left, 11 load
//   SL     serial input entering bit 0 on shift left
//   SR     serial input entering bit 31 on shift right
//   PData  parallel load data
//   Q      registered contents
module shift_reg_32
  import shift_reg_32_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        S1,
  input  logic        S0,
  input  logic        SL,
  input  logic        SR,
  input  logic [31:0] PData,
  output logic [31:0] Q
);

  logic [WIDTH-1:0] qBits;
  logic [WIDTH-1:0] rightChain;
  logic [WIDTH-1:0] leftChain;
  logic [1:0]       mode;

  assign mode = {S1, S0};

  // Neighbour chains: on a right shift bit i takes bit i+1 and bit 31 takes
  // SR; on a left shift bit i takes bit i-1 and bit 0 takes SL. Building
  // them as whole vectors keeps the edge bits out of the generate loop.
  assign rightChain = {SR, qBits[WIDTH-1:1]};
  assign leftChain  = {qBits[WIDTH-2:0], SL};

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    shift_reg_32_cell uCell (
      .clk     (clk),
      .clear   (clear),
      .mode    (mode),
      .rightIn (rightChain[i]),
      .leftIn  (leftChain[i]),
      .loadIn  (PData[i]),
      .q       (qBits[i])
    );
  end

  assign Q = qBits;

endmodule

// File: tb/tb_shift_reg_32.sv
// tb_shift_reg_32
// Scoreboard bench for shift_reg_32. The driver issues one input vector per
// cycle on the falling edge and pushes the expected Q for the coming rising
// edge; the monitor pops one entry after every rising edge and compares.
module tb_shift_reg_32;

  logic        clk;
  logic        clear;
  logic        S1;
  logic        S0;
  logic        SL;
  logic        SR;
  logic [31:0] PData;
  logic [31:0] Q;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } expItem_t;

  expItem_t scoreQ[$];

  int total = 0;
  int bad   = 0;

  // Reference state: the word the register should hold, and whether it is
  // defined yet (it is not until the first clear or load).
  logic [31:0] modelQ;
  bit          modelKnown;

  shift_reg_32 dut (
    .clk   (clk),
    .clear (clear),
    .S1    (S1),
    .S0    (S0),
    .SL    (SL),
    .SR    (SR),
    .PData (PData),
    .Q     (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour expressed as word arithmetic.
  function automatic logic [31:0] nextWord(input logic [31:0] cur, input bit clr,
                                           input int mode, input bit sl,
                                           input bit sr, input logic [31:0] pd);
    if (clr) return 32'd0;
    if (mode == 1) return (cur >> 1) + (sr ? 32'h8000_0000 : 32'd0);
    if (mode == 2) return (cur << 1) + (sl ? 32'd1 : 32'd0);
    if (mode == 3) return pd;
    return cur;
  endfunction

  // Drive one cycle of inputs and queue the expected result. When useConst
  // is set the expected value is a hand-worked constant instead of the model.
  task automatic applyStimulus(input bit clr, input int mode, input bit sl,
                               input bit sr, input logic [31:0] pd,
                               input string name, input bit useConst = 1'b0,
                               input logic [31:0] constExp = 32'd0);
    expItem_t item;
    @(negedge clk);
    clear = clr;
    S1    = mode[1];
    S0    = mode[0];
    SL    = sl;
    SR    = sr;
    PData = pd;
    modelQ = nextWord(modelQ, clr, mode, sl, sr, pd);
    if (clr || mode == 3) modelKnown = 1'b1;
    if (modelKnown) begin
      item.exp  = useConst ? constExp : modelQ;
      item.name = name;
      scoreQ.push_back(item);
    end
  endtask

  task automatic checkOutput(input expItem_t item);
    total++;
    if (Q !== item.exp) begin
      bad++;
      $display("[TB] FAIL %s: Q=0x%08h expected 0x%08h", item.name, Q, item.exp);
    end
  endtask

  // Monitor: one queued expectation per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
  end

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit sl;
    bit sr;
    modelQ     = 32'd0;
    modelKnown = 1'b0;
    clear = 1'b0; S1 = 1'b0; S0 = 1'b0; SL = 1'b0; SR = 1'b0; PData = 32'd0;

    // Clear priority over a simultaneous load.
    applyStimulus(1, 0, 0, 0, 32'h0, "initClear", 1, 32'h0);
    applyStimulus(0, 3, 0, 0, 32'hDEAD_BEEF, "loadDeadBeef", 1, 32'hDEAD_BEEF);
    applyStimulus(1, 3, 1, 1, 32'hFFFF_FFFF, "clearOverLoad", 1, 32'h0);

    // Load then shift right with ones.
    applyStimulus(0, 3, 0, 0, 32'h8000_0000, "load80", 1, 32'h8000_0000);
    applyStimulus(0, 1, 0, 1, 32'h0, "shr1", 1, 32'hC000_0000);
    for (int i = 2; i <= 30; i++) applyStimulus(0, 1, 0, 1, 32'h0, "shrRun");
    applyStimulus(0, 1, 0, 1, 32'h0, "shr31", 1, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 0, 1, 32'h0, "shr32", 1, 32'hFFFF_FFFF);

    // Shift right with zero fill.
    applyStimulus(0, 3, 0, 0, 32'hAAAA_AAAA, "loadAA", 1, 32'hAAAA_AAAA);
    applyStimulus(0, 1, 1, 0, 32'hFFFF_FFFF, "shrZero1", 1, 32'h5555_5555);
    applyStimulus(0, 1, 1, 0, 32'hFFFF_FFFF, "shrZero2", 1, 32'h2AAA_AAAA);

    // Shift left with ones.
    applyStimulus(0, 3, 0, 0, 32'hAAAA_AAAA, "loadAA2", 1, 32'hAAAA_AAAA);
    applyStimulus(0, 2, 1, 0, 32'h0, "shl1", 1, 32'h5555_5555);
    applyStimulus(0, 2, 1, 0, 32'h0, "shl2", 1, 32'hAAAA_AAAB);
    for (int i = 3; i <= 31; i++) applyStimulus(0, 2, 1, 0, 32'h0, "shlRun");
    applyStimulus(0, 2, 1, 0, 32'h0, "shl32", 1, 32'hFFFF_FFFF);

    // Hold while every data input toggles.
    applyStimulus(0, 3, 0, 0, 32'h1234_5678, "load1234", 1, 32'h1234_5678);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, i[0], ~i[0], $urandom(), "hold", 1, 32'h1234_5678);

    // Back-to-back loads with SL high.
    applyStimulus(0, 3, 1, 1, 32'hAAAA_AAAA, "b2bLoad1", 1, 32'hAAAA_AAAA);
    applyStimulus(0, 3, 1, 1, 32'h8000_0000, "b2bLoad2", 1, 32'h8000_0000);

    // Clear in the middle of a shift, then resume shifting from zero.
    applyStimulus(0, 2, 1, 0, 32'h0, "preClearShl", 1, 32'h0000_0001);
    applyStimulus(1, 2, 1, 0, 32'h0, "midClear", 1, 32'h0);
    applyStimulus(0, 2, 1, 0, 32'h0, "resume1", 1, 32'h0000_0001);
    applyStimulus(0, 2, 1, 0, 32'h0, "resume2", 1, 32'h0000_0003);

    // Randomized traffic against the word-level model.
    for (int i = 0; i < 300; i++) begin
      sl = bit'($urandom_range(0, 1));
      sr = bit'($urandom_range(0, 1));
      applyStimulus(($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)),
                    sl, sr, $urandom(), "random");
    end

    // Let the monitor drain the queue, with a bounded wait.
    @(negedge clk);
    for (int i = 0; i < 10 && scoreQ.size() > 0; i++) @(negedge clk);
    if (scoreQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: pending=%0d expected 0", scoreQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
